// File: rtl/i8088_bus_pkg.sv
// Shared types and helpers for the 8088 local-bus HOLD/HLDA arbiter.
package i8088_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    GRANT     = 2'd2,
    RELEASE   = 2'd3
  } hold_state_t;

  localparam int DEF_NREQ       = 2;
  localparam int DEF_MAX_TENURE = 16;
  localparam int DEF_CNT_W      = 8;
  localparam int OWNER_W        = 3;

  // Index of the set bit in a one-hot vector of up to 8 requesters (0 if none).
  function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/i8088_hold_arbiter_rr_pick.sv
// Combinational round-robin picker: the requester at 'ptr' has highest
// priority, priority then falls off in increasing index order with wrap.
module rr_pick
  import i8088_bus_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               valid,
  output logic [NREQ-1:0]    gnt,
  output logic [OWNER_W-1:0] idx
);

  int         best_d_s;
  int         best_j_s;
  int         dist_s;
  logic [7:0] oh_s;

  // Find the requesting index closest to the pointer (cyclic distance).
  always_comb begin
    best_d_s = NREQ;
    best_j_s = 0;
    dist_s   = 0;
    gnt      = {NREQ{1'b0}};
    oh_s     = 8'd0;
    for (int j = 0; j < NREQ; j++) begin
      dist_s = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NREQ - int'(ptr));
      if (req[j] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        best_j_s = j;
      end else begin
        best_d_s = best_d_s;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      gnt[j] = (j == best_j_s) && (best_d_s < NREQ);
    end
    oh_s[NREQ-1:0] = gnt;
    valid          = |req;
    idx            = onehot_to_index(oh_s);
  end

endmodule

// File: rtl/i8088_hold_arbiter.sv
// Shares the 8088 local bus with NREQ bus masters via HOLD/HLDA. The CPU is
// always given at least one clock between grants; each grant is capped at
// MAX_TENURE cycles (0 = unlimited) and round-robin rotates after each grant.
module i8088_hold_arbiter
  import i8088_bus_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NREQ-1:0]    REQ,
  input  logic               HLDA,
  output logic               HOLD,
  output logic [NREQ-1:0]    GNT,
  output logic [OWNER_W-1:0] OWNER,
  output logic               BUSY
);

  localparam bit                 TEN_EN   = (MAX_TENURE != 0);
  localparam logic [CNT_W-1:0]   TEN_LAST = TEN_EN ? CNT_W'(MAX_TENURE - 1) : {CNT_W{1'b0}};
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NREQ - 1);

  hold_state_t        state_r, state_nxt_s;
  logic               hold_r, hold_nxt_s;
  logic [NREQ-1:0]    gnt_r, gnt_nxt_s;
  logic [OWNER_W-1:0] owner_r, owner_nxt_s;
  logic [OWNER_W-1:0] ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               busy_r;

  logic               pick_valid_s;
  logic [NREQ-1:0]    pick_gnt_s;
  logic [OWNER_W-1:0] pick_idx_s;
  logic               owner_req_s;
  logic               tenure_end_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s)
  );

  // Current owner's request level and the end-of-grant condition.
  always_comb begin
    owner_req_s = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      owner_req_s = owner_req_s | (REQ[j] & (owner_r == OWNER_W'(j)));
    end
    tenure_end_s = ~owner_req_s | (TEN_EN & (cnt_r == TEN_LAST));
  end

  // Next-state and next-output logic of the HOLD/HLDA handshake.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    gnt_nxt_s   = gnt_r;
    owner_nxt_s = owner_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        gnt_nxt_s = {NREQ{1'b0}};
        if (|REQ) begin
          hold_nxt_s  = 1'b1;
          state_nxt_s = WAIT_HLDA;
        end else begin
          hold_nxt_s  = 1'b0;
        end
      end
      WAIT_HLDA: begin
        if (HLDA) begin
          if (pick_valid_s) begin
            gnt_nxt_s   = pick_gnt_s;
            owner_nxt_s = pick_idx_s;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = GRANT;
          end else begin
            // Requester withdrew before the CPU let go: hand the bus back.
            hold_nxt_s  = 1'b0;
            gnt_nxt_s   = {NREQ{1'b0}};
            state_nxt_s = RELEASE;
          end
        end else begin
          hold_nxt_s = 1'b1;
        end
      end
      GRANT: begin
        if (!HLDA) begin
          // CPU reclaimed the bus unexpectedly; keep the pointer as it was.
          hold_nxt_s  = 1'b0;
          gnt_nxt_s   = {NREQ{1'b0}};
          state_nxt_s = RELEASE;
        end else if (tenure_end_s) begin
          hold_nxt_s  = 1'b0;
          gnt_nxt_s   = {NREQ{1'b0}};
          ptr_nxt_s   = (owner_r == LAST_IDX) ? {OWNER_W{1'b0}} : (owner_r + 3'd1);
          state_nxt_s = RELEASE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      RELEASE: begin
        hold_nxt_s = 1'b0;
        gnt_nxt_s  = {NREQ{1'b0}};
        if (!HLDA) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      default: begin
        hold_nxt_s  = 1'b0;
        gnt_nxt_s   = {NREQ{1'b0}};
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter, pointer and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= IDLE;
      hold_r  <= 1'b0;
      gnt_r   <= {NREQ{1'b0}};
      owner_r <= {OWNER_W{1'b0}};
      ptr_r   <= {OWNER_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      gnt_r   <= gnt_nxt_s;
      owner_r <= owner_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  assign HOLD  = hold_r;
  assign GNT   = gnt_r;
  assign OWNER = owner_r;
  assign BUSY  = busy_r;

endmodule
